// File: rtl/l2_lru_ctrl_if.sv
// Request/response bundle between the L2 cache control logic and the LRU replacement controller.
// The master side issues touch/evict/invalidate/clear requests; the slave side is l2_lru_ctrl.
interface l2_lru_ctrl_if #(
  parameter int unsigned INDEX_BITS = 4
);
  logic                  req_valid;
  logic                  req_ready;
  logic [1:0]            req_op;
  logic [INDEX_BITS-1:0] req_index;
  logic [2:0]            req_way;
  logic                  rsp_valid;
  logic [2:0]            rsp_way;
  logic                  rsp_was_invalid;

  modport master (
    output req_valid, req_op, req_index, req_way,
    input  req_ready, rsp_valid, rsp_way, rsp_was_invalid
  );

  modport slave (
    input  req_valid, req_op, req_index, req_way,
    output req_ready, rsp_valid, rsp_way, rsp_was_invalid
  );
endinterface

// File: rtl/l2_lru_ctrl.sv
// 8-way L2 replacement controller: per-set LRU ages and valid bits, sequenced IDLE/LOOKUP/UPDATE.
// Optional macro L2_INVALID_FIRST_EN makes EVICT prefer the lowest-index invalid way.
module l2_lru_ctrl #(
  parameter int unsigned INDEX_BITS = 4,
  parameter int unsigned WAYS       = 8
) (
  input logic          clk,
  input logic          reset,
  l2_lru_ctrl_if.slave bus
);
  localparam int unsigned NumSets = 1 << INDEX_BITS;

  typedef logic [WAYS-1:0][2:0] age_vec_t;
  typedef logic [WAYS-1:0]      valid_vec_t;

  typedef enum logic [1:0] {
    OpTouch = 2'd0,
    OpEvict = 2'd1,
    OpInval = 2'd2,
    OpClear = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    StIdle,
    StLookup,
    StUpdate
  } state_e;

  function automatic age_vec_t reset_ages();
    age_vec_t r;
    for (int i = 0; i < int'(WAYS); i++) begin
      r[i] = 3'(i);
    end
    return r;
  endfunction

  function automatic logic is_perm(age_vec_t a);
    logic [WAYS-1:0] seen;
    seen = '0;
    for (int i = 0; i < int'(WAYS); i++) begin
      seen[a[i]] = 1'b1;
    end
    return &seen;
  endfunction

  state_e                state_q, state_d;
  op_e                   op_q, op_d;
  logic [INDEX_BITS-1:0] index_q, index_d;
  logic [2:0]            way_q, way_d;
  age_vec_t              new_age_q, new_age_d;
  valid_vec_t            new_valid_q, new_valid_d;
  logic [2:0]            rsp_way_q, rsp_way_d;
  logic                  rsp_inv_q, rsp_inv_d;
  logic                  set_we;

  age_vec_t   age_q   [NumSets];
  valid_vec_t valid_q [NumSets];

  // Lookup datapath: operates on the latched request against the stored set.
  age_vec_t   cur_age;
  valid_vec_t cur_valid;
  age_vec_t   upd_age;
  valid_vec_t upd_valid;
  logic [2:0] lru_way;
  logic [2:0] victim;
  logic [2:0] tgt;
  logic [2:0] tgt_age;
  logic [2:0] lookup_rsp_way;
  logic       lookup_rsp_inv;
`ifdef L2_INVALID_FIRST_EN
  logic [2:0] inv_way;
  logic       any_inv;
`endif

  always_comb begin
    cur_age   = age_q[index_q];
    cur_valid = valid_q[index_q];
    lru_way   = '0;
`ifdef L2_INVALID_FIRST_EN
    inv_way   = '0;
    any_inv   = 1'b0;
`endif
    // Walk downwards so the lowest matching index wins.
    for (int i = int'(WAYS) - 1; i >= 0; i--) begin
      if (cur_age[i] == 3'd0) begin
        lru_way = 3'(i);
      end
`ifdef L2_INVALID_FIRST_EN
      if (!cur_valid[i]) begin
        inv_way = 3'(i);
        any_inv = 1'b1;
      end
`endif
    end
`ifdef L2_INVALID_FIRST_EN
    victim = any_inv ? inv_way : lru_way;
`else
    victim = lru_way;
`endif
    tgt     = (op_q == OpEvict) ? victim : way_q;
    tgt_age = cur_age[tgt];
  end

  always_comb begin
    upd_age        = cur_age;
    upd_valid      = cur_valid;
    lookup_rsp_way = way_q;
    lookup_rsp_inv = 1'b0;
    case (op_q)
      OpTouch, OpEvict: begin
        for (int i = 0; i < int'(WAYS); i++) begin
          if (3'(i) == tgt) begin
            upd_age[i] = 3'd7;
          end else if (cur_age[i] > tgt_age) begin
            upd_age[i] = cur_age[i] - 3'd1;
          end
        end
        upd_valid[tgt] = 1'b1;
        if (op_q == OpEvict) begin
          lookup_rsp_way = victim;
          lookup_rsp_inv = ~cur_valid[victim];
        end
      end
      OpInval: begin
        for (int i = 0; i < int'(WAYS); i++) begin
          if (3'(i) == tgt) begin
            upd_age[i] = 3'd0;
          end else if (cur_age[i] < tgt_age) begin
            upd_age[i] = cur_age[i] + 3'd1;
          end
        end
        upd_valid[tgt] = 1'b0;
      end
      OpClear: begin
        upd_age        = reset_ages();
        upd_valid      = '0;
        lookup_rsp_way = 3'd0;
      end
      default: begin
        upd_age = cur_age;
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    index_d     = index_q;
    way_d       = way_q;
    new_age_d   = new_age_q;
    new_valid_d = new_valid_q;
    rsp_way_d   = rsp_way_q;
    rsp_inv_d   = rsp_inv_q;
    set_we      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          state_d = StLookup;
          op_d    = op_e'(bus.req_op);
          index_d = bus.req_index;
          way_d   = bus.req_way;
        end
      end
      StLookup: begin
        state_d     = StUpdate;
        new_age_d   = upd_age;
        new_valid_d = upd_valid;
        rsp_way_d   = lookup_rsp_way;
        rsp_inv_d   = lookup_rsp_inv;
      end
      StUpdate: begin
        state_d = StIdle;
        set_we  = 1'b1;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      op_q        <= OpTouch;
      index_q     <= '0;
      way_q       <= '0;
      new_age_q   <= '0;
      new_valid_q <= '0;
      rsp_way_q   <= '0;
      rsp_inv_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      index_q     <= index_d;
      way_q       <= way_d;
      new_age_q   <= new_age_d;
      new_valid_q <= new_valid_d;
      rsp_way_q   <= rsp_way_d;
      rsp_inv_q   <= rsp_inv_d;
    end
  end

  // Set write lands on the UPDATE edge, before the next request can be accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < int'(NumSets); s++) begin
        age_q[s]   <= reset_ages();
        valid_q[s] <= '0;
      end
    end else if (set_we) begin
      age_q[index_q]   <= new_age_q;
      valid_q[index_q] <= new_valid_q;
    end
  end

  assign bus.req_ready       = (state_q == StIdle);
  assign bus.rsp_valid       = (state_q == StUpdate);
  assign bus.rsp_way         = rsp_way_q;
  assign bus.rsp_was_invalid = rsp_inv_q;

  a_age_perm: assert property (@(posedge clk) disable iff (reset) set_we |-> is_perm(new_age_q));
  a_rsp_pulse: assert property (@(posedge clk) disable iff (reset) bus.rsp_valid |=> !bus.rsp_valid);
endmodule

// File: tb/tb_l2_lru_ctrl.sv
// Self-checking bench for l2_lru_ctrl: scoreboard fed by a small LRU model plus scenario checks.
module tb_l2_lru_ctrl;
  localparam int unsigned IndexBits = 4;
  localparam int          NumSets   = 16;

  typedef struct packed {
    logic [2:0] way;
    logic       inv;
  } rsp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  l2_lru_ctrl_if #(.INDEX_BITS(IndexBits)) bus ();

  l2_lru_ctrl #(.INDEX_BITS(IndexBits), .WAYS(8)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  logic [2:0] m_age   [NumSets][8];
  logic [7:0] m_valid [NumSets];
  rsp_t       exp_q[$];
  int         n_cmp;
  int         n_bad;

  function automatic void m_clear_set(input int s);
    for (int w = 0; w < 8; w++) m_age[s][w] = 3'(w);
    m_valid[s] = '0;
  endfunction

  function automatic void m_clear_all();
    for (int s = 0; s < NumSets; s++) m_clear_set(s);
  endfunction

  function automatic rsp_t m_apply(input int op, input int s, input int w);
    rsp_t       r;
    int         vic;
    int         t;
    logic [2:0] a;
    vic = -1;
`ifdef L2_INVALID_FIRST_EN
    for (int i = 0; i < 8; i++) if (vic < 0 && !m_valid[s][i]) vic = i;
`endif
    if (vic < 0) for (int i = 0; i < 8; i++) if (m_age[s][i] == 3'd0) vic = i;
    r.way = 3'(w);
    r.inv = 1'b0;
    if (op == 3) begin
      m_clear_set(s);
      r.way = 3'd0;
    end else begin
      t = (op == 1) ? vic : w;
      a = m_age[s][t];
      if (op == 1) begin
        r.way = 3'(vic);
        r.inv = !m_valid[s][vic];
      end
      for (int i = 0; i < 8; i++) begin
        if (i == t) m_age[s][i] = (op == 2) ? 3'd0 : 3'd7;
        else if (op != 2 && m_age[s][i] > a) m_age[s][i] = m_age[s][i] - 3'd1;
        else if (op == 2 && m_age[s][i] < a) m_age[s][i] = m_age[s][i] + 3'd1;
      end
      m_valid[s][t] = (op != 2);
    end
    return r;
  endfunction

  // Issue one request, score its response, then check the stored set against the model.
  task automatic do_req(input int op, input int s, input int w,
                        output logic [2:0] rway, output logic rinv);
    int                 cyc;
    rsp_t               e;
    logic [7:0][2:0]    ea;
    logic [7:0]         seen;
    rway = '0;
    rinv = 1'b0;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b1;
    bus.req_op    = 2'(op);
    bus.req_index = 4'(s);
    bus.req_way   = 3'(w);
    cyc = 0;
    @(negedge clk);
    while (!bus.req_ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    if (!bus.req_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout op=%0d set=%0d: req_ready=%b, required 1", op, s, bus.req_ready);
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    exp_q.push_back(m_apply(op, s, w));
    cyc = 0;
    @(negedge clk);
    while (!bus.rsp_valid && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    e = exp_q.pop_front();
    n_cmp++;
    if (!bus.rsp_valid) begin
      n_bad++;
      $display("FAIL rsp_timeout op=%0d set=%0d: rsp_valid=%b, required 1", op, s, bus.rsp_valid);
      return;
    end
    if ({bus.rsp_way, bus.rsp_was_invalid} !== e) begin
      n_bad++;
      $display("FAIL scoreboard op=%0d set=%0d: way=%0d inv=%b, required way=%0d inv=%b",
               op, s, bus.rsp_way, bus.rsp_was_invalid, e.way, e.inv);
    end
    rway = bus.rsp_way;
    rinv = bus.rsp_was_invalid;
    @(negedge clk);
    for (int i = 0; i < 8; i++) ea[i] = m_age[s][i];
    n_cmp++;
    if (dut.age_q[s] !== ea || dut.valid_q[s] !== m_valid[s]) begin
      n_bad++;
      $display("FAIL set_state set=%0d: ages=%h valid=%b, required ages=%h valid=%b",
               s, dut.age_q[s], dut.valid_q[s], ea, m_valid[s]);
    end
    seen = '0;
    for (int i = 0; i < 8; i++) seen[dut.age_q[s][i]] = 1'b1;
    n_cmp++;
    if (seen !== 8'hFF) begin
      n_bad++;
      $display("FAIL age_perm set=%0d: ages seen=%b, required 11111111", s, seen);
    end
  endtask

  task automatic test_reset();
    bus.req_valid = 1'b1;
    bus.req_op    = 2'd1;
    bus.req_index = '0;
    bus.req_way   = '0;
    repeat (2) @(posedge clk);
    #1;
    reset         = 1'b0;
    bus.req_valid = 1'b0;
    m_clear_all();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_way !== 3'd0 ||
          bus.rsp_was_invalid !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_state c=%0d: ready=%b rsp_valid=%b way=%0d inv=%b, required 1 0 0 0",
                 c, bus.req_ready, bus.rsp_valid, bus.rsp_way, bus.rsp_was_invalid);
      end
    end
  endtask

  task automatic test_evict_fill();
    logic [2:0] rw;
    logic       ri;
    rsp_t       e;
    // First EVICT checked cycle by cycle for latency and hold behaviour.
    @(posedge clk);
    #1;
    bus.req_valid = 1'b1;
    bus.req_op    = 2'd1;
    bus.req_index = 4'd0;
    bus.req_way   = 3'd4;
    @(negedge clk);
    n_cmp++;
    if (bus.req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL lat_c0_ready: req_ready=%b, required 1", bus.req_ready);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    e = m_apply(1, 0, 0);
    @(negedge clk);
    n_cmp++;
    if (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL lat_c1: ready=%b rsp_valid=%b, required 0 0", bus.req_ready, bus.rsp_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.rsp_valid !== 1'b1 || {bus.rsp_way, bus.rsp_was_invalid} !== {3'd0, 1'b1} ||
        e !== {3'd0, 1'b1}) begin
      n_bad++;
      $display("FAIL lat_c2_rsp: valid=%b way=%0d inv=%b, required 1 0 1",
               bus.rsp_valid, bus.rsp_way, bus.rsp_was_invalid);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_way !== 3'd0 ||
        bus.rsp_was_invalid !== 1'b1) begin
      n_bad++;
      $display("FAIL lat_c3_hold: ready=%b valid=%b way=%0d inv=%b, required 1 0 0 1",
               bus.req_ready, bus.rsp_valid, bus.rsp_way, bus.rsp_was_invalid);
    end
    for (int k = 1; k < 8; k++) begin
      do_req(1, 0, 0, rw, ri);
      n_cmp++;
      if (rw !== 3'(k) || ri !== 1'b1) begin
        n_bad++;
        $display("FAIL evict_fill k=%0d: way=%0d inv=%b, required way=%0d inv=1", k, rw, ri, k);
      end
    end
  endtask

  task automatic test_touch_lru();
    logic [2:0] rw;
    logic       ri;
    for (int w = 0; w < 8; w++) do_req(0, 0, w, rw, ri);
    do_req(1, 0, 0, rw, ri);
    n_cmp++;
    if (rw !== 3'd0 || ri !== 1'b0) begin
      n_bad++;
      $display("FAIL touch_lru_a: way=%0d inv=%b, required way=0 inv=0", rw, ri);
    end
    do_req(0, 0, 0, rw, ri);
    do_req(1, 0, 0, rw, ri);
    n_cmp++;
    if (rw !== 3'd1 || ri !== 1'b0) begin
      n_bad++;
      $display("FAIL touch_lru_b: way=%0d inv=%b, required way=1 inv=0", rw, ri);
    end
  endtask

  task automatic test_inval();
    logic [2:0] rw;
    logic       ri;
    for (int w = 0; w < 8; w++) do_req(0, 3, w, rw, ri);
    do_req(2, 3, 5, rw, ri);
    do_req(1, 3, 0, rw, ri);
    n_cmp++;
    if (rw !== 3'd5 || ri !== 1'b1) begin
      n_bad++;
      $display("FAIL inval_evict: way=%0d inv=%b, required way=5 inv=1", rw, ri);
    end
  endtask

  task automatic test_invalid_first();
    logic [2:0]      rw;
    logic            ri;
    logic [2:0]      want;
    logic [7:0][2:0] ea;
    do_req(0, 1, 2, rw, ri);
    do_req(0, 1, 5, rw, ri);
    for (int w = 0; w < 8; w++) do_req(0, 2, w, rw, ri);
    // Way 1 invalidated first, then way 6: way 6 ends at age 0, way 1 at age 1.
    do_req(2, 2, 1, rw, ri);
    do_req(2, 2, 6, rw, ri);
`ifdef L2_INVALID_FIRST_EN
    want = 3'd1;
`else
    want = 3'd6;
`endif
    do_req(1, 2, 0, rw, ri);
    n_cmp++;
    if (rw !== want || ri !== 1'b1) begin
      n_bad++;
      $display("FAIL invalid_first: way=%0d inv=%b, required way=%0d inv=1", rw, ri, want);
    end
    for (int i = 0; i < 8; i++) ea[i] = m_age[1][i];
    n_cmp++;
    if (dut.age_q[1] !== ea || dut.valid_q[1] !== 8'b0010_0100) begin
      n_bad++;
      $display("FAIL set_isolation: set1 ages=%h valid=%b, required ages=%h valid=00100100",
               dut.age_q[1], dut.valid_q[1], ea);
    end
  endtask

  task automatic test_clear_set();
    logic [2:0] rw;
    logic       ri;
    for (int w = 0; w < 8; w++) do_req(0, 7, w, rw, ri);
    do_req(3, 7, 5, rw, ri);
    n_cmp++;
    if (rw !== 3'd0 || ri !== 1'b0) begin
      n_bad++;
      $display("FAIL clear_rsp: way=%0d inv=%b, required way=0 inv=0", rw, ri);
    end
    do_req(1, 7, 0, rw, ri);
    n_cmp++;
    if (rw !== 3'd0 || ri !== 1'b1) begin
      n_bad++;
      $display("FAIL clear_evict: way=%0d inv=%b, required way=0 inv=1", rw, ri);
    end
  endtask

  task automatic test_back_to_back();
    int   acc;
    int   nrsp;
    int   last_acc;
    rsp_t e;
    acc      = 0;
    nrsp     = 0;
    last_acc = -1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b1;
    bus.req_op    = 2'd1;
    bus.req_index = 4'd5;
    bus.req_way   = 3'd0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        n_cmp++;
        if (last_acc >= 0 && c - last_acc != 3) begin
          n_bad++;
          $display("FAIL accept_gap c=%0d: gap=%0d, required 3", c, c - last_acc);
        end
        last_acc = c;
        acc++;
        exp_q.push_back(m_apply(1, 5, 0));
      end
      if (bus.rsp_valid) begin
        e = exp_q.pop_front();
        n_cmp++;
        if ({bus.rsp_way, bus.rsp_was_invalid} !== e || bus.rsp_way !== 3'(nrsp)) begin
          n_bad++;
          $display("FAIL b2b_rsp n=%0d: way=%0d inv=%b, required way=%0d inv=%b",
                   nrsp, bus.rsp_way, bus.rsp_was_invalid, e.way, e.inv);
        end
        nrsp++;
      end
      if (c == 11) bus.req_valid = 1'b0;
    end
    repeat (4) begin
      @(negedge clk);
      if (bus.rsp_valid) nrsp++;
    end
    n_cmp++;
    if (acc !== 4 || nrsp !== 4) begin
      n_bad++;
      $display("FAIL b2b_counts: accepts=%0d rsps=%0d, required 4 4", acc, nrsp);
    end
  endtask

  task automatic test_reset_in_lookup();
    logic [2:0] rw;
    logic       ri;
    int         spurious;
    do_req(0, 4, 3, rw, ri);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b1;
    bus.req_op    = 2'd1;
    bus.req_index = 4'd4;
    bus.req_way   = 3'd0;
    @(negedge clk);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    reset         = 1'b1;
    spurious      = 0;
    @(negedge clk);
    if (bus.rsp_valid) spurious++;
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_clear_all();
    repeat (4) begin
      @(negedge clk);
      if (bus.rsp_valid) spurious++;
    end
    n_cmp++;
    if (spurious != 0 || bus.req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_lookup_drop: spurious rsp=%0d ready=%b, required 0 1",
               spurious, bus.req_ready);
    end
    do_req(1, 4, 0, rw, ri);
    n_cmp++;
    if (rw !== 3'd0 || ri !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_lookup_evict: way=%0d inv=%b, required way=0 inv=1", rw, ri);
    end
  endtask

  initial begin
    n_cmp         = 0;
    n_bad         = 0;
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_index = '0;
    bus.req_way   = '0;
    test_reset();
    test_evict_fill();
    test_touch_lru();
    test_inval();
    test_invalid_first();
    test_clear_set();
    test_back_to_back();
    test_reset_in_lookup();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d pending, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
